pong_score_keeper: RTL

- Game-flow controller and scoreboard for the Pong datapath, directly downstream of the ball stage.
- Consumes the ball's per-point scoring pulses and the vsync frame strobe.
- Runs the serve/play/pause/game-over state machine and gates ball motion.
- Produces binary scores, BCD hex-digit fields for the seven-segment drivers, and the winner flag.

---
 rtl/pong_score_keeper_if.sv | 30 +++
 rtl/pong_score_keeper.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pong_score_keeper_if.sv
// Signal bundle between the Pong ball/keyboard stages and the score keeper.
// The master side supplies the scoring pulses, serve key and vsync; the
// slave side (the score keeper) returns game flow, scores and display fields.
interface pong_score_keeper_if;
    logic       frame_clk;
    logic       point_l;
    logic       point_r;
    logic       serve_req;
    logic       ball_enable;
    logic       ball_reset;
    logic       serve_dir;
    logic [3:0] leftScore;
    logic [3:0] rightScore;
    logic [7:0] hex_l;
    logic [7:0] hex_r;
    logic [1:0] winner;
    logic [1:0] game_state;

    modport master (
        output frame_clk, point_l, point_r, serve_req,
        input  ball_enable, ball_reset, serve_dir, leftScore, rightScore,
               hex_l, hex_r, winner, game_state
    );

    modport slave (
        input  frame_clk, point_l, point_r, serve_req,
        output ball_enable, ball_reset, serve_dir, leftScore, rightScore,
               hex_l, hex_r, winner, game_state
    );
endinterface

// File: rtl/pong_score_keeper.sv
// Pong game-flow controller and scoreboard. Turns the ball stage's scoring
// pulses into scores, runs serve/play/pause/game-over, gates ball motion and
// builds the BCD fields for the seven-segment drivers.
module pong_score_keeper #(
    parameter int WIN_SCORE    = 9,
    parameter int PAUSE_FRAMES = 60,
    parameter int CNT_W        = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    pong_score_keeper_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PLAY  = 2'b01,
        PAUSE = 2'b10,
        OVER  = 2'b11
    } state_t;

    localparam logic [3:0]       WIN       = 4'(WIN_SCORE);
    localparam logic [CNT_W-1:0] PAUSE_END = CNT_W'(PAUSE_FRAMES);

    state_t           state;
    logic [3:0]       left_score;
    logic [3:0]       right_score;
    logic [1:0]       winner_r;
    logic             serve_dir_r;
    logic             ball_reset_r;
    logic [CNT_W-1:0] pause_cnt;

    // frame_p0/p1 synchronize vsync into Clk, frame_p2 holds the previous
    // synchronized level for rising-edge detection.
    logic frame_p0;
    logic frame_p1;
    logic frame_p2;
    logic serve_p0;

    logic       frame_tick;
    logic       serve_edge;
    logic [3:0] left_next;
    logic [3:0] right_next;

    // Split a score (never above 15) into {tens, ones} BCD digits.
    function automatic logic [7:0] to_bcd(input logic [3:0] score);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = (score >= 4'd10) ? 4'd1 : 4'd0;
        ones = (score >= 4'd10) ? (score - 4'd10) : score;
        return {tens, ones};
    endfunction

    assign frame_tick = frame_p1 & ~frame_p2;
    assign serve_edge = bus.serve_req & ~serve_p0;
    assign left_next  = left_score + 4'd1;
    assign right_next = right_score + 4'd1;

    // Synchronize vsync and remember the last serve key level; both history
    // registers reset high so nothing fires on the first cycle out of reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_p0 <= 1'b0;
            frame_p1 <= 1'b0;
            frame_p2 <= 1'b1;
            serve_p0 <= 1'b1;
        end else begin
            frame_p0 <= bus.frame_clk;
            frame_p1 <= frame_p0;
            frame_p2 <= frame_p1;
            serve_p0 <= bus.serve_req;
        end
    end

    // Game-flow FSM with registered scores, winner, serve direction and ball reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            left_score   <= 4'd0;
            right_score  <= 4'd0;
            winner_r     <= 2'b00;
            serve_dir_r  <= 1'b0;
            ball_reset_r <= 1'b0;
            pause_cnt    <= '0;
        end else begin
            ball_reset_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (serve_edge) begin
                        state <= PLAY;
                    end
                end
                PLAY: begin
                    if (bus.point_l && bus.point_r) begin
                        // Simultaneous points cancel: recenter and pause only.
                        ball_reset_r <= 1'b1;
                        pause_cnt    <= '0;
                        state        <= PAUSE;
                    end else if (bus.point_l) begin
                        left_score   <= left_next;
                        serve_dir_r  <= 1'b1;
                        ball_reset_r <= 1'b1;
                        pause_cnt    <= '0;
                        if (left_next == WIN) begin
                            winner_r <= 2'b01;
                            state    <= OVER;
                        end else begin
                            state <= PAUSE;
                        end
                    end else if (bus.point_r) begin
                        right_score  <= right_next;
                        serve_dir_r  <= 1'b0;
                        ball_reset_r <= 1'b1;
                        pause_cnt    <= '0;
                        if (right_next == WIN) begin
                            winner_r <= 2'b10;
                            state    <= OVER;
                        end else begin
                            state <= PAUSE;
                        end
                    end
                end
                PAUSE: begin
                    // The compare comes first so PAUSE_FRAMES=0 leaves after one cycle.
                    if (pause_cnt == PAUSE_END) begin
                        state <= PLAY;
                    end else if (frame_tick) begin
                        pause_cnt <= pause_cnt + CNT_W'(1);
                    end
                end
                OVER: begin
                    if (serve_edge) begin
                        left_score   <= 4'd0;
                        right_score  <= 4'd0;
                        winner_r     <= 2'b00;
                        ball_reset_r <= 1'b1;
                        pause_cnt    <= '0;
                        state        <= PAUSE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ball_enable = (state == PLAY);
    assign bus.ball_reset  = ball_reset_r;
    assign bus.serve_dir   = serve_dir_r;
    assign bus.leftScore   = left_score;
    assign bus.rightScore  = right_score;
    assign bus.hex_l       = to_bcd(left_score);
    assign bus.hex_r       = to_bcd(right_score);
    assign bus.winner      = winner_r;
    assign bus.game_state  = state;

endmodule
